// File: rtl/snoop_sram_arbiter.sv
// rtl/snoop_sram_arbiter.sv - SRAM arbiter between CPU ports and a snoop controller
// Round-robin CPU arbitration with snoop priority bounded by a starvation counter, plus lock ownership.
module snoop_sram_arbiter #(
  parameter int NUM_PORTS  = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] lock_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  input  logic                 snoop_req_i,
  input  logic                 snoop_lock_i,
  output logic                 snoop_gnt_o,
  input  logic                 miss_busy_i,
  output logic                 sram_req_o,
  input  logic                 sram_gnt_i,
  output logic [NUM_PORTS:0]   sel_o,
  output logic                 busy_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int OW = $clog2(NUM_PORTS + 1);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [OW-1:0] SNOOP_IDX  = OW'(NUM_PORTS);
  localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_PORTS - 1);
  localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [PW-1:0]   rr_ptr, rr_nxt;
  logic [CW-1:0]   starve_cnt, starve_nxt;

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [PW:0]            scan_sum;
  logic                   cpu_found;
  logic [PW-1:0]          cpu_idx;

  logic                   win_valid;
  logic [OW-1:0]          win_idx;
  logic [NUM_PORTS:0]     win_oh;
  logic [NUM_PORTS:0]     owner_oh;
  logic                   owner_req, owner_lock, win_lock, accepted;
  logic [NUM_PORTS-1:0]   gnt_c;
  logic                   snoop_gnt_c, sram_req_c;
  logic [NUM_PORTS:0]     sel_c;

  // Rotate requests so bit 0 is rr_ptr, then take the first set bit and map back.
  always_comb begin
    req_dbl   = {req_i, req_i} >> rr_ptr;
    req_rot   = req_dbl[NUM_PORTS-1:0];
    cpu_found = 1'b0;
    cpu_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!cpu_found && req_rot[k]) begin
        cpu_found = 1'b1;
        scan_sum  = {1'b0, rr_ptr} + (PW+1)'(k);
        if (scan_sum >= (PW+1)'(NUM_PORTS)) scan_sum = scan_sum - (PW+1)'(NUM_PORTS);
        cpu_idx   = scan_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_nxt      = rr_ptr;
    starve_nxt  = starve_cnt;
    win_valid   = 1'b0;
    win_idx     = '0;
    gnt_c       = '0;
    snoop_gnt_c = 1'b0;
    sram_req_c  = 1'b0;
    sel_c       = '0;

    owner_oh   = (NUM_PORTS+1)'(1) << owner;
    owner_req  = |(owner_oh & {snoop_req_i, req_i});
    owner_lock = |(owner_oh & {snoop_lock_i, lock_i});

    case (state)
      IDLE: begin
        if (!miss_busy_i) begin
          if (snoop_req_i && (starve_cnt < STARVE_TOP || req_i == '0)) begin
            win_valid = 1'b1;
            win_idx   = SNOOP_IDX;
          end else if (cpu_found) begin
            win_valid = 1'b1;
            win_idx   = OW'(cpu_idx);
          end
        end
      end
      LOCKED: begin
        if (owner_req) begin
          win_valid = 1'b1;
          win_idx   = owner;
        end
      end
      default: ;
    endcase

    win_oh   = (NUM_PORTS+1)'(1) << win_idx;
    win_lock = |(win_oh & {snoop_lock_i, lock_i});
    accepted = win_valid && sram_gnt_i;

    if (win_valid) begin
      sram_req_c = 1'b1;
      sel_c      = win_oh;
      if (sram_gnt_i) {snoop_gnt_c, gnt_c} = win_oh;
    end

    if (state == IDLE) begin
      if (accepted && win_lock) begin
        state_nxt = LOCKED;
        owner_nxt = win_idx;
      end
    end else if (!owner_lock && (!owner_req || sram_gnt_i)) begin
      state_nxt = IDLE;
    end

    if (accepted && win_idx != SNOOP_IDX) begin
      rr_nxt     = (PW'(win_idx) == LAST_PORT) ? '0 : PW'(win_idx) + PW'(1);
      starve_nxt = '0;
    end else if (accepted && state == IDLE && req_i != '0) begin
      if (starve_cnt != STARVE_TOP) starve_nxt = starve_cnt + CW'(1);
    end
    if (req_i == '0) starve_nxt = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      rr_ptr     <= rr_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Outputs are forced quiet while reset is held, even though grants are combinational.
  assign gnt_o       = rst_i ? '0 : gnt_c;
  assign snoop_gnt_o = !rst_i && snoop_gnt_c;
  assign sram_req_o  = !rst_i && sram_req_c;
  assign sel_o       = rst_i ? '0 : sel_c;
  assign busy_o      = !rst_i && (state == LOCKED);

endmodule

// File: doc/snoop_sram_arbiter.md
SNOOP_SRAM_ARBITER -- requirements
Module: snoop_sram_arbiter

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_PORTS, default 3, SHALL set the number of CPU-side requesters (cache controllers and miss handler).
REQ-003 Parameter STARVE_MAX, default 4, SHALL set the maximum number of consecutive snoop grants while any CPU request is pending.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_i  in  NUM_PORTS  CPU port i requests the SRAM.
REQ-007 lock_i  in  NUM_PORTS  CPU port i asks to keep ownership after the current access.
REQ-008 gnt_o  out  NUM_PORTS  the access of CPU port i is accepted this cycle.
REQ-009 snoop_req_i  in  1  snoop controller requests the SRAM.
REQ-010 snoop_lock_i  in  1  snoop controller asks to keep ownership (read-then-update sequence).
REQ-011 snoop_gnt_o  out  1  the snoop access is accepted this cycle.
REQ-012 miss_busy_i  in  1  miss handler is updating the cache; blocks new arbitration.
REQ-013 sram_req_o  out  1  request forwarded to the SRAM.
REQ-014 sram_gnt_i  in  1  SRAM accepts the forwarded request.
REQ-015 sel_o  out  NUM_PORTS+1  one-hot select for the data/address mux; bit NUM_PORTS = snoop; all-zero when nothing is forwarded.
REQ-016 busy_o  out  1  high while in LOCKED.

Function
REQ-017 The FSM SHALL have two states, IDLE and LOCKED, with registered owner, rr_ptr (clog2 NUM_PORTS bits) and starve_cnt (0..STARVE_MAX, saturating).
REQ-018 IDLE with miss_busy_i=1: sram_req_o=0, sel_o=0, all grants 0, state unchanged.
REQ-019 IDLE with miss_busy_i=0: winner = snoop if snoop_req_i=1 and (starve_cnt<STARVE_MAX or req_i==0); otherwise the first set req_i bit searching upward from rr_ptr with wrap-around.
REQ-020 Grants SHALL be combinational, with zero-cycle latency: sram_req_o=1 and sel_o=onehot(winner) in the same cycle; the winner's grant = sram_gnt_i; every other grant = 0.
REQ-021 Accepted winner with its lock bit set -> LOCKED with owner=winner; without lock -> stay IDLE and re-arbitrate next cycle.
REQ-022 No request, or sram_gnt_i=0: no state, pointer or counter change.
REQ-023 LOCKED: only the owner is forwarded (sram_req_o = owner req, sel_o = onehot(owner) when it requests); all other grants = 0; miss_busy_i is ignored.
REQ-024 LOCKED -> IDLE when the owner's lock bit is 0 and either (owner req=1 and sram_gnt_i=1) or owner req=0.
REQ-025 LOCKED with owner lock=1 SHALL stay LOCKED regardless of sram_gnt_i.
REQ-026 On every accepted CPU grant (IDLE or LOCKED): rr_ptr = (granted index+1) mod NUM_PORTS, with wrap from NUM_PORTS-1 to 0; starve_cnt=0.
REQ-027 On an accepted snoop grant while req_i!=0: starve_cnt increments, saturating at STARVE_MAX.
REQ-028 When req_i==0, starve_cnt SHALL be cleared.
REQ-029 In LOCKED with snoop owner, snoop accesses SHALL NOT increment starve_cnt.
REQ-030 The grant vector {snoop_gnt_o, gnt_o} SHALL be one-hot or zero in every cycle.
REQ-031 When a locked owner and a new requester assert in the same cycle, the owner always wins until its release.

Reset
REQ-032 During rst_i=1 and in the first cycle after it: state=IDLE, owner=0, rr_ptr=0, starve_cnt=0.
REQ-033 While rst_i=1, all outputs SHALL be 0 (gnt_o, snoop_gnt_o, sram_req_o, sel_o, busy_o).
REQ-034 Reset asserted in LOCKED SHALL drop ownership immediately with no completion of the pending access.

Verification
REQ-035 req_i=3'b111, sram_gnt_i=1, no lock, 3 cycles -> gnt_o = 001, 010, 100; rr_ptr returns to 0.
REQ-036 snoop_req_i=1 and req_i=3'b001 held, sram_gnt_i=1 -> snoop granted 4 cycles, then gnt_o[0] for 1 cycle, then snoop again; starve_cnt sequence 1,2,3,4,0.
REQ-037 snoop_req_i=snoop_lock_i=1 granted, then req_i=3'b010 for 3 cycles with snoop_lock_i=1 -> gnt_o=0 and busy_o=1 for all 3 cycles; snoop_lock_i=0 with access granted -> IDLE, port 1 granted next cycle.
REQ-038 miss_busy_i=1 with all requests high -> sram_req_o=0 and no grants; miss_busy_i asserted while in LOCKED -> owner keeps its grants.
REQ-039 sram_gnt_i=0 with req_i=3'b100 -> sram_req_o=1, sel_o=4'b0100, gnt_o=0, rr_ptr unchanged.
REQ-040 rst_i pulsed while LOCKED (owner=port 2) -> next cycle busy_o=0 and rr_ptr=0; req_i=3'b111 then grants port 0 first.
